exec_branch_unit: RTL and testbench
===================================

# exec_branch_unit

Parametrised branch execution unit for the exec stage. It resolves JAL, JALR and all six RV conditional branches, and checks that the next decoded instruction follows each resolved branch, whether taken or not taken. On a mispredict it issues a registered redirect and runs a fixed-length recovery window. It also keeps saturating branch and mispredict counters for perf CSRs.

## Interface
Parameters:
- XLEN, default 64, data width of rs1_data, rs2_data and result.
- ALEN, default 64, address width.
- FLUSH_CYCLES, default 2, recovery window length in cycles; must be ≥1.
- CNT_W, default 32, perf counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- input_valid  in  1  decode slot valid and not on a mispredicted path.
- input_valid_unless_mispredict  in  1  decode slot valid, ignoring the mispredict check.
- input_is_branch  in  1  slot is routed to this unit.
- opcode  in  5  instr[6:2]: JAL=11011, JALR=11001, BRANCH=11000.
- funct3  in  3.
- rs1_data, rs2_data  in  XLEN each.
- i_imm  in  12  instr[31:20].
- j_imm  in  20  J-immediate bits [20:1].
- b_imm  in  12  B-immediate bits [12:1].
- decode_instruction_addr, decode_instruction_next_addr  in  ALEN each.
- output_valid  out  1.
- exception  out  1.
- taken  out  1.
- result  out  XLEN  link value written to rd.
- target  out  ALEN  resolved next PC.
- mispredict_detected  out  1  combinational.
- redirect_valid  out  1  one-cycle pulse.
- redirect_addr  out  ALEN.
- recovering  out  1.
- branch_count  out  CNT_W.
- mispredict_count  out  CNT_W.

## Operation
- Accept condition: input_valid && input_is_branch && !recovering && !mispredict_detected.
- Target computation:
  - JAL: addr + sext({j_imm,0}).
  - JALR: (rs1_data + sext(i_imm)) with bit0 cleared.
  - BRANCH: addr + sext({b_imm,0}).
  - All adds are mod 2^ALEN.
- Conditions by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed, XLEN).
  - 110 BLTU, 111 BGEU (unsigned).
  - JAL and JALR are always taken.
- Illegal instruction: JALR with funct3≠0; BRANCH with funct3 010 or 011; any other opcode. An illegal instruction forces taken=0.
- exception = illegal, or (taken and target[0]=1).
- target = taken ? computed target : next_addr.
- result = decode_instruction_next_addr, zero-extended or truncated to XLEN.
- Expected-PC tracker (exp_valid, exp_pc):
  - On accept with no exception: exp_valid←1, exp_pc←target.
  - On accept with exception: exp_valid←0.
  - When input_valid_unless_mispredict is high and no branch is accepted: exp_valid←0.
- mispredict_detected = !recovering && input_valid_unless_mispredict && exp_valid && exp_pc≠decode_instruction_addr. The slot is discarded regardless of input_valid.
- FSM, IDLE→RECOVER:
  - On mispredict_detected in IDLE: next cycle redirect_valid=1, redirect_addr=exp_pc, exp_valid←0, load countdown FLUSH_CYCLES, state RECOVER.
  - In RECOVER: recovering=1, all inputs ignored, exp_* frozen, countdown decrements each cycle.
  - Countdown reaching 0 returns to IDLE.
- Counters saturate at 2^CNT_W−1:
  - branch_count +1 on each accept.
  - mispredict_count +1 on each redirect.
- Reset: every registered output is 0, exp_valid=0, state IDLE, countdown 0.

## Timing
- Latency: output_valid, exception, taken, result and target are registered, asserted the cycle after accept. output_valid is a 1-cycle pulse per accept.
- result, target, taken and exception hold their values when not accepting.
- Redirect: detection in cycle N → redirect_valid in cycle N+1 → recovering high in cycles N+1 .. N+FLUSH_CYCLES → next accept possible in cycle N+FLUSH_CYCLES+1.
- Back-to-back accepts are allowed every cycle in IDLE. A branch in cycle N is checked against decode_instruction_addr in the next cycle in which input_valid_unless_mispredict is high.
- Bubbles (input_valid_unless_mispredict=0) leave exp_* unchanged.
- rst during RECOVER returns to IDLE immediately, clearing the redirect and recovering outputs.
- Counters update in the same cycle as output_valid or redirect_valid.

## Test plan
- BEQ at addr 0x1000, rs1=rs2=5, b_imm=0x10 (offset 0x20) → next cycle output_valid=1, taken=1, target=0x1020, result=0x1004. Next instr at 0x1020 → no mispredict; branch_count=1.
- BLT at 0x2000 with rs1=−1, rs2=1 → taken. BLTU with the same operands → not taken, target=next_addr 0x2004. Next decoded instr at 0x2010 → mispredict_detected=1, then redirect_valid pulse with redirect_addr=0x2004, recovering high for exactly FLUSH_CYCLES cycles, mispredict_count=1.
- JALR with rs1=0x3001, i_imm=0x002 → target=0x3002, exception=0. JALR with funct3=001 → exception=1, taken=0, exp_valid cleared so no mispredict follows.
- JAL with a target whose bit0=1 (compressed next_addr=addr+2 case) → exception=1. Misaligned not-taken BNE → exception=0.
- Mispredict while input_valid=1 and input_is_branch=1 → slot not accepted, no output_valid. Branches presented during RECOVER are ignored. rst asserted during RECOVER → next cycle recovering=0.
- CNT_W=2 run of 5 branches → branch_count sticks at 3.

Source files
------------

// File: rtl/exec_branch_unit.sv
// exec_branch_unit: resolves JAL/JALR/conditional branches in the exec stage,
// checks that the next decoded instruction follows each resolved branch, and
// on a mispredict issues a registered redirect and a fixed-length recovery
// window. Keeps saturating branch / mispredict counters for perf CSRs.
module exec_branch_unit #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned ALEN         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_valid,
  input  logic             input_valid_unless_mispredict,
  input  logic             input_is_branch,
  input  logic [4:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [11:0]      i_imm,
  input  logic [19:0]      j_imm,
  input  logic [11:0]      b_imm,
  input  logic [ALEN-1:0]  decode_instruction_addr,
  input  logic [ALEN-1:0]  decode_instruction_next_addr,
  output logic             output_valid,
  output logic             exception,
  output logic             taken,
  output logic [XLEN-1:0]  result,
  output logic [ALEN-1:0]  target,
  output logic             mispredict_detected,
  output logic             redirect_valid,
  output logic [ALEN-1:0]  redirect_addr,
  output logic             recovering,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  localparam int unsigned CD_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RECOVER
  } state_t;

  state_t            state;
  logic [CD_W-1:0]   countdown;

  // Expected-PC tracker: where the next decoded instruction must come from
  logic              exp_valid;
  logic [ALEN-1:0]   exp_pc;

  // Target datapath
  logic [ALEN-1:0]   jal_off;
  logic [ALEN-1:0]   br_off;
  logic [ALEN-1:0]   jalr_off;
  logic [ALEN-1:0]   jal_tgt;
  logic [ALEN-1:0]   br_tgt;
  logic [ALEN-1:0]   jalr_sum;
  logic [ALEN-1:0]   jalr_tgt;

  // Resolution of the slot currently presented
  logic              illegal;
  logic              cond;
  logic [ALEN-1:0]   comp_tgt;
  logic              taken_next;
  logic [ALEN-1:0]   target_next;
  logic              exception_next;
  logic              accept;

  // Immediates are sign-extended to the address width before the adds
  assign jal_off  = ALEN'($signed({j_imm, 1'b0}));
  assign br_off   = ALEN'($signed({b_imm, 1'b0}));
  assign jalr_off = ALEN'($signed(i_imm));

  assign jal_tgt  = decode_instruction_addr + jal_off;
  assign br_tgt   = decode_instruction_addr + br_off;
  assign jalr_sum = ALEN'(rs1_data) + jalr_off;
  assign jalr_tgt = {jalr_sum[ALEN-1:1], 1'b0};

  // Decode legality, branch condition and the computed target by opcode
  always_comb begin
    illegal  = 1'b0;
    cond     = 1'b0;
    comp_tgt = br_tgt;
    case (opcode)
      OP_JAL: begin
        cond     = 1'b1;
        comp_tgt = jal_tgt;
      end
      OP_JALR: begin
        cond     = 1'b1;
        comp_tgt = jalr_tgt;
        illegal  = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        comp_tgt = br_tgt;
        case (funct3)
          3'b000:  cond = (rs1_data == rs2_data);
          3'b001:  cond = (rs1_data != rs2_data);
          3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  cond = (rs1_data <  rs2_data);
          3'b111:  cond = (rs1_data >= rs2_data);
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // An illegal instruction never redirects; a misaligned target only faults when taken
  assign taken_next     = cond && !illegal;
  assign target_next    = taken_next ? comp_tgt : decode_instruction_next_addr;
  assign exception_next = illegal || (taken_next && target_next[0]);

  assign mispredict_detected = !recovering && input_valid_unless_mispredict &&
                               exp_valid && (exp_pc != decode_instruction_addr);

  assign accept = input_valid && input_is_branch && !recovering && !mispredict_detected;

  // Registered resolution results; values hold between accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      output_valid <= 1'b0;
      exception    <= 1'b0;
      taken        <= 1'b0;
      result       <= '0;
      target       <= '0;
    end else begin
      output_valid <= accept;
      if (accept) begin
        exception <= exception_next;
        taken     <= taken_next;
        result    <= XLEN'(decode_instruction_next_addr);
        target    <= target_next;
      end
    end
  end

  // Expected-PC tracker; frozen while recovering, bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_valid <= 1'b0;
      exp_pc    <= '0;
    end else if (!recovering) begin
      if (mispredict_detected) begin
        exp_valid <= 1'b0;
      end else if (accept) begin
        exp_valid <= !exception_next;
        if (!exception_next) begin
          exp_pc <= target_next;
        end
      end else if (input_valid_unless_mispredict) begin
        exp_valid <= 1'b0;
      end
    end
  end

  // Redirect / recovery FSM: the countdown is loaded with the window length and
  // the exit happens on the cycle it would reach zero, so recovering stays high
  // for exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      countdown      <= '0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      recovering     <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mispredict_detected) begin
            state          <= RECOVER;
            countdown      <= CD_W'(FLUSH_CYCLES);
            redirect_valid <= 1'b1;
            redirect_addr  <= exp_pc;
            recovering     <= 1'b1;
          end
        end
        RECOVER: begin
          if (countdown <= CD_W'(1)) begin
            state      <= IDLE;
            countdown  <= '0;
            recovering <= 1'b0;
          end else begin
            countdown <= countdown - CD_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          countdown  <= '0;
          recovering <= 1'b0;
        end
      endcase
    end
  end

  // Saturating perf counters, updated alongside output_valid / redirect_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (accept && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict_detected && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exec_branch_unit.sv
// Self-checking bench for exec_branch_unit: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the branch unit.
module tb_exec_branch_unit;

  localparam int unsigned FL = 2;
  localparam logic [4:0] JAL = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001;
  localparam logic [4:0] BR = 5'b11000;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid, input_valid_unless_mispredict, input_is_branch;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data;
  logic [11:0] i_imm;
  logic [19:0] j_imm;
  logic [11:0] b_imm;
  logic [63:0] decode_instruction_addr, decode_instruction_next_addr;

  logic        output_valid, exception, taken, mispredict_detected;
  logic        redirect_valid, recovering;
  logic [63:0] result, target, redirect_addr;
  logic [31:0] branch_count, mispredict_count;

  logic        s_output_valid, s_exception, s_taken, s_mispredict_detected;
  logic        s_redirect_valid, s_recovering;
  logic [63:0] s_result, s_target, s_redirect_addr;
  logic [1:0]  s_branch_count, s_mispredict_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_branch_unit #(.XLEN(64), .ALEN(64), .FLUSH_CYCLES(FL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid),
    .input_valid_unless_mispredict(input_valid_unless_mispredict),
    .input_is_branch(input_is_branch),
    .opcode(opcode), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .i_imm(i_imm), .j_imm(j_imm), .b_imm(b_imm),
    .decode_instruction_addr(decode_instruction_addr),
    .decode_instruction_next_addr(decode_instruction_next_addr),
    .output_valid(output_valid), .exception(exception), .taken(taken),
    .result(result), .target(target),
    .mispredict_detected(mispredict_detected),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .recovering(recovering),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  exec_branch_unit #(.XLEN(64), .ALEN(64), .FLUSH_CYCLES(FL), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .input_valid(input_valid),
    .input_valid_unless_mispredict(input_valid_unless_mispredict),
    .input_is_branch(input_is_branch),
    .opcode(opcode), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .i_imm(i_imm), .j_imm(j_imm), .b_imm(b_imm),
    .decode_instruction_addr(decode_instruction_addr),
    .decode_instruction_next_addr(decode_instruction_next_addr),
    .output_valid(s_output_valid), .exception(s_exception), .taken(s_taken),
    .result(s_result), .target(s_target),
    .mispredict_detected(s_mispredict_detected),
    .redirect_valid(s_redirect_valid), .redirect_addr(s_redirect_addr),
    .recovering(s_recovering),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        ill;
    logic        tk;
    logic [63:0] tg;
  } res_t;

  function automatic res_t resolve(input logic [4:0] op, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [11:0] ii, input logic [19:0] jj,
                                   input logic [11:0] bb, input logic [63:0] pc);
    res_t   r;
    longint off;
    logic   c;
    r = '0;
    c = 1'b0;
    if (op == JAL) begin
      off = longint'(jj) * 2;
      if (off >= 1048576) off -= 2097152;
      r.tg = pc + off;
      r.tk = 1'b1;
    end else if (op == JALR) begin
      off = longint'(ii);
      if (off >= 2048) off -= 4096;
      r.tg = (a + off) & ~64'd1;
      r.ill = (f3 != 3'd0);
      r.tk = !r.ill;
    end else if (op == BR) begin
      off = longint'(bb) * 2;
      if (off >= 4096) off -= 8192;
      r.tg = pc + off;
      case (f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = (longint'(a) < longint'(b));
        3'd5: c = (longint'(a) >= longint'(b));
        3'd6: c = (a < b);
        3'd7: c = (a >= b);
        default: r.ill = 1'b1;
      endcase
      r.tk = c && !r.ill;
    end else begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  logic        m_ov = 0, m_exc = 0, m_tk = 0, m_rv = 0, m_exp_v = 0;
  logic [63:0] m_res = 0, m_tg = 0, m_raddr = 0, m_exp_pc = 0;
  int          m_rec = 0;
  longint      m_bc = 0, m_mc = 0;
  logic        armed = 0;
  logic        mis_c, acc, exc_c;
  logic [63:0] tgt_c;
  res_t        rr;

  // Compare DUT state against the model, then advance the model by one cycle
  always @(negedge clk) begin
    mis_c = (m_rec == 0) && input_valid_unless_mispredict && m_exp_v &&
            (m_exp_pc != decode_instruction_addr);
    acc = input_valid && input_is_branch && (m_rec == 0) && !mis_c;
    rr = resolve(opcode, funct3, rs1_data, rs2_data, i_imm, j_imm, b_imm,
                 decode_instruction_addr);
    tgt_c = rr.tk ? rr.tg : decode_instruction_next_addr;
    exc_c = rr.ill || (rr.tk && rr.tg[0]);
    if (armed) begin
      chk("output_valid", 64'(output_valid), 64'(m_ov));
      chk("exception", 64'(exception), 64'(m_exc));
      chk("taken", 64'(taken), 64'(m_tk));
      chk("result", result, m_res);
      chk("target", target, m_tg);
      chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
      chk("redirect_addr", redirect_addr, m_raddr);
      chk("recovering", 64'(recovering), 64'(m_rec > 0));
      chk("branch_count", 64'(branch_count), 64'(m_bc));
      chk("mispredict_count", 64'(mispredict_count), 64'(m_mc));
      chk("mispredict_detected", 64'(mispredict_detected), 64'(mis_c));
      chk("sat_branch_count", 64'(s_branch_count), 64'((m_bc > 3) ? 3 : m_bc));
      chk("sat_mispredict_count", 64'(s_mispredict_count), 64'((m_mc > 3) ? 3 : m_mc));
    end
    if (rst) begin
      m_ov = 0; m_exc = 0; m_tk = 0; m_res = 0; m_tg = 0;
      m_rv = 0; m_raddr = 0; m_rec = 0; m_exp_v = 0; m_exp_pc = 0;
      m_bc = 0; m_mc = 0;
      armed = 1;
    end else begin
      m_ov = acc;
      m_rv = mis_c;
      if (acc) begin
        m_exc = exc_c;
        m_tk  = rr.tk;
        m_tg  = tgt_c;
        m_res = decode_instruction_next_addr;
        m_bc++;
      end
      if (mis_c) begin
        m_raddr = m_exp_pc;
        m_mc++;
      end
      if (m_rec > 0) m_rec--;
      else if (mis_c) begin
        m_rec = FL;
        m_exp_v = 0;
      end else if (acc) begin
        m_exp_v = !exc_c;
        if (!exc_c) m_exp_pc = tgt_c;
      end else if (input_valid_unless_mispredict) m_exp_v = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic v, input logic vum, input logic br,
                      input logic [4:0] op, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [11:0] ii, input logic [19:0] jj, input logic [11:0] bb,
                      input logic [63:0] pc, input logic [63:0] npc);
    input_valid = v;
    input_valid_unless_mispredict = vum;
    input_is_branch = br;
    opcode = op; funct3 = f3;
    rs1_data = a; rs2_data = b;
    i_imm = ii; j_imm = jj; b_imm = bb;
    decode_instruction_addr = pc;
    decode_instruction_next_addr = npc;
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'd5;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [63:0] a, b, pc;
    logic        vum;

    rst = 1'b1;
    slot(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'd0, 64'd0);
    step(); step();
    chk("pin_reset_output_valid", 64'(output_valid), 64'd0);
    chk("pin_reset_recovering", 64'(recovering), 64'd0);
    chk("pin_reset_branch_count", 64'(branch_count), 64'd0);
    rst = 1'b0;

    // BEQ taken
    slot(1, 1, 1, BR, 3'd0, 64'd5, 64'd5, 12'd0, 20'd0, 12'h010, 64'h1000, 64'h1004);
    step();
    chk("pin_beq_valid", 64'(output_valid), 64'd1);
    chk("pin_beq_taken", 64'(taken), 64'd1);
    chk("pin_beq_target", target, 64'h1020);
    chk("pin_beq_result", result, 64'h1004);
    chk("pin_beq_count", 64'(branch_count), 64'd1);
    slot(1, 1, 0, 5'b00100, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'h1020, 64'h1024);
    #1;
    chk("pin_beq_follow_nomis", 64'(mispredict_detected), 64'd0);
    step();

    // BLT signed taken, then BLTU not taken, then a wrong-path fetch
    slot(1, 1, 1, BR, 3'd4, '1, 64'd1, 12'd0, 20'd0, 12'h080, 64'h1f00, 64'h1f04);
    step();
    chk("pin_blt_taken", 64'(taken), 64'd1);
    chk("pin_blt_target", target, 64'h2000);
    slot(1, 1, 1, BR, 3'd6, '1, 64'd1, 12'd0, 20'd0, 12'h080, 64'h2000, 64'h2004);
    #1;
    chk("pin_bltu_nomis", 64'(mispredict_detected), 64'd0);
    step();
    chk("pin_bltu_taken", 64'(taken), 64'd0);
    chk("pin_bltu_target", target, 64'h2004);
    slot(1, 1, 1, BR, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'h004, 64'h2010, 64'h2014);
    #1;
    chk("pin_mis_detected", 64'(mispredict_detected), 64'd1);
    step();
    chk("pin_mis_no_accept", 64'(output_valid), 64'd0);
    chk("pin_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("pin_redirect_addr", redirect_addr, 64'h2004);
    chk("pin_recovering_1", 64'(recovering), 64'd1);
    chk("pin_mis_count", 64'(mispredict_count), 64'd1);
    step();
    chk("pin_recovering_2", 64'(recovering), 64'd1);
    chk("pin_redirect_pulse", 64'(redirect_valid), 64'd0);
    chk("pin_recover_ignored", 64'(output_valid), 64'd0);
    slot(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'd0, 64'd0);
    step();
    chk("pin_recovering_end", 64'(recovering), 64'd0);

    // JALR legal, JALR illegal funct3
    slot(1, 1, 1, JALR, 3'd0, 64'h3001, 64'd0, 12'h002, 20'd0, 12'd0, 64'h3000, 64'h3004);
    step();
    chk("pin_jalr_target", target, 64'h3002);
    chk("pin_jalr_exc", 64'(exception), 64'd0);
    slot(1, 1, 1, JALR, 3'd1, 64'h3001, 64'd0, 12'h002, 20'd0, 12'd0, 64'h3002, 64'h3006);
    step();
    chk("pin_jalr_bad_exc", 64'(exception), 64'd1);
    chk("pin_jalr_bad_taken", 64'(taken), 64'd0);

    // JAL to an odd target, then misaligned but not-taken BNE
    slot(1, 1, 1, JAL, 3'd0, 64'd0, 64'd0, 12'd0, 20'd2, 12'd0, 64'h4001, 64'h4003);
    #1;
    chk("pin_after_exc_nomis", 64'(mispredict_detected), 64'd0);
    step();
    chk("pin_jal_odd_exc", 64'(exception), 64'd1);
    slot(1, 1, 1, BR, 3'd1, 64'd7, 64'd7, 12'd0, 20'd0, 12'h008, 64'h6001, 64'h6003);
    step();
    chk("pin_bne_nt_exc", 64'(exception), 64'd0);
    chk("pin_bne_nt_target", target, 64'h6003);

    // Reset while recovering
    slot(0, 1, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'h7000, 64'h7004);
    step();
    chk("pin_rr_redirect_addr", redirect_addr, 64'h6003);
    rst = 1'b1;
    slot(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'd0, 64'd0);
    step();
    chk("pin_rr_recovering", 64'(recovering), 64'd0);
    chk("pin_rr_redirect", 64'(redirect_valid), 64'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      vum = ($urandom_range(0, 99) < 85);
      case ($urandom_range(0, 3))
        0: op = JAL;
        1: op = JALR;
        2: op = BR;
        default: op = 5'($urandom_range(0, 31));
      endcase
      f3 = 3'($urandom_range(0, 7));
      if (op == JALR && $urandom_range(0, 3) != 0) f3 = 3'd0;
      a = pick_val();
      b = ($urandom_range(0, 2) == 0) ? a : pick_val();
      if (m_exp_v && $urandom_range(0, 9) < 7) pc = m_exp_pc;
      else if ($urandom_range(0, 3) == 0) pc = {$urandom, $urandom};
      else pc = 64'($urandom_range(0, 65535));
      slot(vum && ($urandom_range(0, 9) != 0), vum, ($urandom_range(0, 9) < 7),
           op, f3, a, b, 12'($urandom), 20'($urandom), 12'($urandom),
           pc, pc + (($urandom_range(0, 1) == 1) ? 64'd4 : 64'd2));
      step();
    end

    // Saturation: five chained JALs after reset
    rst = 1'b1;
    slot(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'd0, 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      slot(1, 1, 1, JAL, 3'd0, 64'd0, 64'd0, 12'd0, 20'd2, 12'd0,
           64'h8000 + 64'(4 * k), 64'h8004 + 64'(4 * k));
      step();
    end
    chk("pin_sat_branch_count", 64'(s_branch_count), 64'd3);
    chk("pin_full_branch_count", 64'(branch_count), 64'd5);
    slot(0, 0, 0, 5'd0, 3'd0, 64'd0, 64'd0, 12'd0, 20'd0, 12'd0, 64'd0, 64'd0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
